// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flags register,
// driven by control_unit strobes and feeding the single-port program/data RAM.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_HALT, I_BRANCH, I_BZERO, I_BNEG, I_LOAD, I_STORE,
        I_MOVE, I_ADD, I_SUB, I_OR, I_AND
    } decoded_instruction_type;
endpackage

module data_path #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 branch,
    input  logic                                 pc_enable,
    input  logic                                 ir_enable,
    input  logic                                 write_reg_enable,
    input  logic                                 addr_sel,
    input  logic                                 c_sel,
    input  logic [1:0]                           operation,
    input  logic                                 flags_reg_enable,
    input  logic [DATA_W-1:0]                    data_in,
    output logic [ADDR_W-1:0]                    ram_addr,
    output logic [DATA_W-1:0]                    data_out,
    output k_and_s_pkg::decoded_instruction_type decoded_instruction,
    output logic                                 zero_op,
    output logic                                 neg_op,
    output logic                                 unsigned_overflow,
    output logic                                 signed_overflow
);
    import k_and_s_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [3:0]        flags_q, flags_d;   // {zero, neg, unsigned, signed}

    logic [1:0]        a_idx, b_idx, c_idx;
    logic [DATA_W-1:0] a_val, b_val, alu_res, c_bus;
    logic [DATA_W:0]   sum_ext;
    logic              alu_uflow, alu_sflow;
    logic              ir_unused;

    assign ir_unused = ir_q[7];

    always_comb begin
        decoded_instruction = I_NOP;
        c_idx = ir_q[5:4];
        a_idx = ir_q[3:2];
        b_idx = ir_q[1:0];
        case (ir_q[15:8])
            8'h00: decoded_instruction = I_NOP;
            8'hFF: decoded_instruction = I_HALT;
            8'h01: decoded_instruction = I_BRANCH;
            8'h02: decoded_instruction = I_BZERO;
            8'h03: decoded_instruction = I_BNEG;
            8'h81: begin
                decoded_instruction = I_LOAD;
                c_idx = ir_q[6:5];
            end
            8'h82: begin
                decoded_instruction = I_STORE;
                a_idx = ir_q[6:5];
            end
            8'h91: begin
                decoded_instruction = I_MOVE;
                b_idx = ir_q[3:2];
            end
            8'hA1: decoded_instruction = I_ADD;
            8'hA2: decoded_instruction = I_SUB;
            8'hA3: decoded_instruction = I_OR;
            8'hA4: decoded_instruction = I_AND;
            default: decoded_instruction = I_NOP;
        endcase
    end

    assign a_val   = regs_q[a_idx];
    assign b_val   = regs_q[b_idx];
    assign sum_ext = {1'b0, a_val} + {1'b0, b_val};

    always_comb begin
        alu_res   = '0;
        alu_uflow = 1'b0;
        alu_sflow = 1'b0;
        case (operation)
            2'b00: alu_res = a_val | b_val;
            2'b01: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_uflow = sum_ext[DATA_W];
                alu_sflow = (a_val[DATA_W-1] == b_val[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            2'b10: begin
                alu_res   = a_val - b_val;
                alu_uflow = a_val < b_val;
                alu_sflow = (a_val[DATA_W-1] != b_val[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            default: alu_res = a_val & b_val;
        endcase
    end

    assign c_bus = c_sel ? alu_res : data_in;

    // All next-state values come from pre-edge registers, so simultaneous strobes stay independent
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        flags_d = flags_q;
        if (pc_enable)
            pc_d = branch ? pc_q + ADDR_W'(1) : ir_q[ADDR_W-1:0];
        if (ir_enable)
            ir_d = data_in;
        if (write_reg_enable)
            regs_d[c_idx] = c_bus;
        if (flags_reg_enable)
            flags_d = {(alu_res == '0), alu_res[DATA_W-1], alu_uflow, alu_sflow};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

    assign ram_addr          = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign data_out          = a_val;
    assign zero_op           = flags_q[3];
    assign neg_op            = flags_q[2];
    assign unsigned_overflow = flags_q[1];
    assign signed_overflow   = flags_q[0];
endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: decode, ALU/flags, PC, register
// file, simultaneous strobes and mid-sequence reset.
module tb_data_path;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel;
    logic flags_reg_enable;
    logic [1:0]  operation;
    logic [15:0] data_in;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_path dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .write_reg_enable(write_reg_enable),
        .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
        .flags_reg_enable(flags_reg_enable), .data_in(data_in),
        .ram_addr(ram_addr), .data_out(data_out),
        .decoded_instruction(decoded_instruction), .zero_op(zero_op),
        .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow)
    );

    function automatic logic [3:0] flags();
        return {zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        c_sel = 0; operation = 2'b00; flags_reg_enable = 0;
    endtask

    task automatic set_ir(input logic [15:0] v);
        data_in = v; ir_enable = 1;
        tick();
        ir_enable = 0;
    endtask

    task automatic load_reg(input logic [1:0] idx, input logic [15:0] v);
        set_ir(16'h8100 | {9'b0, idx, 5'b0});
        data_in = v; c_sel = 0; write_reg_enable = 1;
        tick();
        write_reg_enable = 0;
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [15:0] v);
        set_ir(16'h8200 | {9'b0, idx, 5'b0});
        v = data_out;
    endtask

    task automatic alu_op(input logic [15:0] ir, input logic [1:0] op,
                          input logic we, input logic fe);
        set_ir(ir);
        operation = op; c_sel = 1; write_reg_enable = we; flags_reg_enable = fe;
        tick();
        clear_strobes();
    endtask

    task automatic test_reset();
        rst_n = 0; clear_strobes(); addr_sel = 0; data_in = 16'hFFFF;
        tick(); tick();
        rst_n = 1;
        total++; if (ram_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", ram_addr); end
        total++; if (decoded_instruction !== I_NOP) begin bad++; $display("FAIL reset_decode got=%0d exp=%0d", decoded_instruction, I_NOP); end
        total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags()); end
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h exp=0000", data_out); end
    endtask

    logic [15:0]             dec_ir  [15] = '{16'h0000, 16'hFF00, 16'h0103, 16'h0203, 16'h0303,
                                              16'h8125, 16'h8243, 16'h9108, 16'hA100, 16'hA200,
                                              16'hA300, 16'hA400, 16'h5500, 16'hA500, 16'h8000};
    decoded_instruction_type dec_exp [15] = '{I_NOP, I_HALT, I_BRANCH, I_BZERO, I_BNEG,
                                              I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB,
                                              I_OR, I_AND, I_NOP, I_NOP, I_NOP};

    task automatic test_decode();
        data_in = 16'h8125; ir_enable = 1;
        total++; if (decoded_instruction !== I_NOP) begin bad++; $display("FAIL dec_latency got=%0d exp=%0d", decoded_instruction, I_NOP); end
        tick(); ir_enable = 0;
        total++; if (decoded_instruction !== I_LOAD) begin bad++; $display("FAIL dec_load got=%0d exp=%0d", decoded_instruction, I_LOAD); end
        addr_sel = 1;
        #1;
        total++; if (ram_addr !== 5'd5) begin bad++; $display("FAIL addr_ir got=%0d exp=5", ram_addr); end
        addr_sel = 0;
        for (int i = 0; i < 15; i++) begin
            set_ir(dec_ir[i]);
            total++;
            if (decoded_instruction !== dec_exp[i]) begin
                bad++; $display("FAIL decode ir=%h got=%0d exp=%0d", dec_ir[i], decoded_instruction, dec_exp[i]);
            end
        end
    endtask

    task automatic test_alu();
        logic [15:0] v;
        load_reg(2'd1, 16'h7FFF);
        load_reg(2'd2, 16'h0001);
        alu_op(16'hA136, 2'b01, 1, 1);
        total++; if (flags() !== 4'b0101) begin bad++; $display("FAIL add_flags got=%b exp=0101", flags()); end
        read_reg(2'd3, v);
        total++; if (v !== 16'h8000) begin bad++; $display("FAIL add_result got=%h exp=8000", v); end
        alu_op(16'hA20A, 2'b10, 1, 1);
        total++; if (flags() !== 4'b1000) begin bad++; $display("FAIL sub_zero_flags got=%b exp=1000", flags()); end
        alu_op(16'hA40F, 2'b11, 0, 0);
        total++; if (flags() !== 4'b1000) begin bad++; $display("FAIL and_hold_flags got=%b exp=1000", flags()); end
        alu_op(16'hA10F, 2'b01, 0, 1);
        total++; if (flags() !== 4'b1011) begin bad++; $display("FAIL add_carry_flags got=%b exp=1011", flags()); end
        alu_op(16'hA209, 2'b10, 1, 1);
        total++; if (flags() !== 4'b0110) begin bad++; $display("FAIL sub_borrow_flags got=%b exp=0110", flags()); end
        read_reg(2'd0, v);
        total++; if (v !== 16'h8002) begin bad++; $display("FAIL sub_result got=%h exp=8002", v); end
        alu_op(16'hA20D, 2'b10, 0, 1);
        total++; if (flags() !== 4'b0001) begin bad++; $display("FAIL sub_sflow_flags got=%b exp=0001", flags()); end
        alu_op(16'hA306, 2'b00, 0, 1);
        total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL or_flags got=%b exp=0000", flags()); end
    endtask

    task automatic test_pc();
        addr_sel = 0;
        set_ir(16'h011F);
        pc_enable = 1; branch = 0; tick(); pc_enable = 0;
        total++; if (ram_addr !== 5'd31) begin bad++; $display("FAIL pc_load31 got=%0d exp=31", ram_addr); end
        pc_enable = 1; branch = 1; tick(); pc_enable = 0;
        total++; if (ram_addr !== 5'd0) begin bad++; $display("FAIL pc_wrap got=%0d exp=0", ram_addr); end
        set_ir(16'h0114);
        pc_enable = 1; branch = 0; tick(); pc_enable = 0;
        total++; if (ram_addr !== 5'd20) begin bad++; $display("FAIL pc_branch got=%0d exp=20", ram_addr); end
        pc_enable = 1; branch = 1; tick(); pc_enable = 0; branch = 0;
        total++; if (ram_addr !== 5'd21) begin bad++; $display("FAIL pc_inc got=%0d exp=21", ram_addr); end
    endtask

    task automatic test_store_move();
        logic [15:0] v;
        load_reg(2'd2, 16'hBEEF);
        set_ir(16'h8243);
        total++; if (decoded_instruction !== I_STORE) begin bad++; $display("FAIL store_decode got=%0d exp=%0d", decoded_instruction, I_STORE); end
        total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL store_dout got=%h exp=beef", data_out); end
        addr_sel = 1; #1;
        total++; if (ram_addr !== 5'd3) begin bad++; $display("FAIL store_addr got=%0d exp=3", ram_addr); end
        addr_sel = 0;
        alu_op(16'h9108, 2'b00, 1, 0);
        read_reg(2'd0, v);
        total++; if (v !== 16'hBEEF) begin bad++; $display("FAIL move_result got=%h exp=beef", v); end
    endtask

    task automatic test_back_to_back();
        set_ir(16'h8124);
        data_in = 16'h1234; c_sel = 0; write_reg_enable = 1;
        #1;
        total++; if (data_out !== 16'h7FFF) begin bad++; $display("FAIL same_cycle_read got=%h exp=7fff", data_out); end
        tick(); write_reg_enable = 0;
        total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL post_write_read got=%h exp=1234", data_out); end
        set_ir(16'h0105);
        data_in = 16'h010A; ir_enable = 1; pc_enable = 1; branch = 0;
        tick(); clear_strobes();
        addr_sel = 0; #1;
        total++; if (ram_addr !== 5'd5) begin bad++; $display("FAIL simul_pc got=%0d exp=5", ram_addr); end
        addr_sel = 1; #1;
        total++; if (ram_addr !== 5'd10) begin bad++; $display("FAIL simul_ir got=%0d exp=10", ram_addr); end
        addr_sel = 0;
        pc_enable = 1; tick(); pc_enable = 0;
        total++; if (ram_addr !== 5'd10) begin bad++; $display("FAIL next_branch got=%0d exp=10", ram_addr); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        alu_op(16'hA136, 2'b01, 1, 1);
        total++; if (flags() !== 4'b0100) begin bad++; $display("FAIL pre_reset_flags got=%b exp=0100", flags()); end
        read_reg(2'd3, v);
        total++; if (v !== 16'hD123) begin bad++; $display("FAIL pre_reset_reg3 got=%h exp=d123", v); end
        rst_n = 0; pc_enable = 1; branch = 1; ir_enable = 1; data_in = 16'hA136;
        write_reg_enable = 1; flags_reg_enable = 1; c_sel = 1; operation = 2'b01;
        tick();
        clear_strobes(); rst_n = 1; addr_sel = 0; #1;
        total++; if (ram_addr !== 5'd0) begin bad++; $display("FAIL mid_reset_pc got=%0d exp=0", ram_addr); end
        total++; if (decoded_instruction !== I_NOP) begin bad++; $display("FAIL mid_reset_ir got=%0d exp=%0d", decoded_instruction, I_NOP); end
        total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL mid_reset_flags got=%b exp=0000", flags()); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i[1:0], v);
            total++; if (v !== 16'h0000) begin bad++; $display("FAIL mid_reset_reg%0d got=%h exp=0000", i, v); end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alu();
        test_pc();
        test_store_move();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
